// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register for a writeback-bound stage (control + data payload).
// Define PIPE_STAGE_SKID_BUF_EN to add a skid entry that registers in_ready.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 101,
    parameter int unsigned CTRL_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              accept;

`ifdef PIPE_STAGE_SKID_BUF_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;

    assign in_ready = in_ready_q;
    assign accept   = in_valid & in_ready_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_ctrl_d   = out_ctrl_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q) begin
            if (accept) begin
                out_valid_d = 1'b1;
                out_ctrl_d  = in_ctrl;
                out_data_d  = in_data;
            end
        end else if (out_ready) begin
            // Skid entry (older) takes the output slot before any new input.
            if (skid_valid_q) begin
                out_ctrl_d   = skid_ctrl_q;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_ctrl_d = in_ctrl;
                out_data_d = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
`else
    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = in_ctrl;
            out_data_d  = in_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign occupancy = {1'b0, out_valid_q};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_data_q  <= out_data_d;
        end
    end

    // Bubbles must never carry RegWriteEn; data is left holding its last value.
    assign out_valid = out_valid_q;
    assign out_ctrl  = out_valid_q ? out_ctrl_q : '0;
    assign out_data  = out_data_q;

endmodule
